// File: rtl/muldiv_pkg.sv
// Shared constants, types and decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned MULDIV_ITER = 32;
  localparam int unsigned CNT_W       = 6;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Request captured at acceptance; opnd is the multiplicand or divisor magnitude
  typedef struct packed {
    logic [2:0]      op;
    logic            sign_a;
    logic            sign_b;
    logic            b_zero;
    logic [XLEN-1:0] opnd;
  } muldiv_req_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; 0x80..0 maps to itself, read as an unsigned magnitude.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout_c
);

  // Negate when requested, pass through otherwise
  assign dout_c = neg ? W'(~din + W'(1)) : din;

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps on magnitudes, then one sign-fix cycle.
module execute_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MulDivOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result
);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  muldiv_req_t       req;
  muldiv_req_t       req_c;
  logic [2*XLEN-1:0] acc;

  logic              a_neg_c;
  logic              b_neg_c;
  logic [XLEN-1:0]   mag_a_c;
  logic [XLEN-1:0]   mag_b_c;
  logic              last_iter_c;

  logic [XLEN-1:0]   mul_addend_c;
  logic [XLEN:0]     mul_sum_c;
  logic [2*XLEN-1:0] acc_mul_next_c;
  logic              div_ge_c;
  logic [XLEN-1:0]   div_rem_c;
  logic [2*XLEN-1:0] acc_div_next_c;

  logic              neg_prod_c;
  logic              neg_quo_c;
  logic [2*XLEN-1:0] prod_fix_c;
  logic [XLEN-1:0]   quo_fix_c;
  logic [XLEN-1:0]   rem_fix_c;
  logic [XLEN-1:0]   result_c;

  // Operand signs and magnitudes taken straight from the request ports
  assign a_neg_c = op_a_signed(MulDivOp) & SrcA[XLEN-1];
  assign b_neg_c = op_b_signed(MulDivOp) & SrcB[XLEN-1];

  muldiv_signfix #(.W(XLEN)) u_mag_a (.neg(a_neg_c), .din(SrcA), .dout_c(mag_a_c));
  muldiv_signfix #(.W(XLEN)) u_mag_b (.neg(b_neg_c), .din(SrcB), .dout_c(mag_b_c));

  // Assemble the request captured on acceptance
  always_comb begin
    req_c        = '0;
    req_c.op     = MulDivOp;
    req_c.sign_a = a_neg_c;
    req_c.sign_b = b_neg_c;
    req_c.b_zero = (SrcB == '0);
    req_c.opnd   = op_is_div(MulDivOp) ? mag_b_c : mag_a_c;
  end

  assign last_iter_c = (cnt == CNT_W'(MULDIV_ITER - 1));

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  assign mul_addend_c   = acc[0] ? req.opnd : '0;
  assign mul_sum_c      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend_c};
  assign acc_mul_next_c = {mul_sum_c, acc[XLEN-1:1]};

  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}
  assign div_ge_c       = (acc[2*XLEN-1:XLEN-1] >= {1'b0, req.opnd});
  assign div_rem_c      = acc[2*XLEN-2:XLEN-1] - req.opnd;
  assign acc_div_next_c = div_ge_c ? {div_rem_c, acc[XLEN-2:0], 1'b1}
                                   : {acc[2*XLEN-2:0], 1'b0};

  // Divide by zero keeps the all-ones quotient regardless of dividend sign
  assign neg_prod_c = req.sign_a ^ req.sign_b;
  assign neg_quo_c  = (req.sign_a ^ req.sign_b) & ~req.b_zero;

  muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.neg(neg_prod_c), .din(acc), .dout_c(prod_fix_c));
  muldiv_signfix #(.W(XLEN)) u_fix_quo (.neg(neg_quo_c), .din(acc[XLEN-1:0]), .dout_c(quo_fix_c));
  muldiv_signfix #(.W(XLEN)) u_fix_rem (.neg(req.sign_a), .din(acc[2*XLEN-1:XLEN]), .dout_c(rem_fix_c));

  // Result word selection by operation
  always_comb begin
    result_c = rem_fix_c;
    case (req.op)
      OP_MUL:                         result_c = prod_fix_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   result_c = prod_fix_c[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                result_c = quo_fix_c;
      default:                        result_c = rem_fix_c;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter_c) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: capture, iterate, sign-fix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req    <= '0;
      acc    <= '0;
      cnt    <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req <= req_c;
            acc <= {{XLEN{1'b0}}, (op_is_div(MulDivOp) ? mag_a_c : mag_b_c)};
            cnt <= '0;
          end
        end
        CALC: begin
          acc <= op_is_div(req.op) ? acc_div_next_c : acc_mul_next_c;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: Result <= result_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: vector table, scoreboard and handshake corner cases.
module tb_execute_muldiv;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  execute_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .MulDivOp(MulDivOp),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference arithmetic independent of the iterative datapath
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    logic ovf;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = ua64 * ub64;  return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=Result 0x%08h required=no done", Result);
      end else begin
        chk("result", Result, sb_q.pop_front());
      end
    end
  end

  // Issue one operation and check latency, busy duration and return to idle
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit scramble);
    int n, busy_cnt;
    bit got;
    @(negedge clk);
    MulDivOp = op; SrcA = a; SrcB = b; start = 1'b1;
    sb_q.push_back(exp);
    n = 0; busy_cnt = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk); n++; #1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) got = 1'b1;
      if (!got) begin
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
          SrcA = $urandom; SrcB = $urandom; MulDivOp = 3'($urandom);
        end
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", n, 34);
    chk("busy_cycles", busy_cnt, 34);
    @(posedge clk); #1;
    chk("idle_after_done", {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int done_cnt, first_done, prev_done, gap_bad, stray;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
    vecs[7]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{OP_REMU,   32'd5,         32'd0,         32'd5};
    vecs[9]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[11] = '{OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
    vecs[12] = '{OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    vecs[13] = '{OP_MULHU,  32'h8000_0000, 32'd2,         32'd1};
    vecs[14] = '{OP_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000};
    vecs[15] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[16] = '{OP_MUL,    32'h1234_5678, 32'd0,         32'd0};

    reset = 1'b1; start = 1'b0; MulDivOp = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", Result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors
    for (int i = 0; i < NVEC; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

    // Operands scrambled while computing must not disturb the result
    do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom); ra = $urandom; rb = (i % 4 == 3) ? 32'd0 : $urandom;
      do_op(rop, ra, rb, model(rop, ra, rb), (i % 2) == 1);
    end

    // start held high: accepted only in IDLE, one result per 35 cycles
    @(negedge clk);
    MulDivOp = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
    repeat (3) sb_q.push_back(32'd14);
    done_cnt = 0; first_done = 0; prev_done = 0; gap_bad = 0;
    for (int e = 1; e <= 105; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) first_done = e;
        else if (e - prev_done != 35) gap_bad++;
        prev_done = e;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_done_count", done_cnt, 3);
    chk("held_first_done", first_done, 34);
    chk("held_period_errors", gap_bad, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_idle", 32'(busy), 32'd0);

    // Reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    MulDivOp = OP_MUL; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", Result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    chk("abort_no_activity", stray, 0);

    // First start after reset completes normally
    do_op(OP_MULH, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 1'b0);
    do_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
